modport_spi: RTL and testbench



---
 rtl/modport_spi_pkg.sv | 21 ++
 rtl/modport_spi_clkgen.sv | 38 +++
 rtl/modport_spi.sv | 117 +++++++++++
 tb/tb_modport_spi.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/modport_spi_pkg.sv
// Shared types and defaults for the modport_spi SPI master.
// Optional build macro SPI_LOOPBACK_EN (see modport_spi.sv).
package modport_spi_pkg;

   localparam int WIDTH_DEF   = 65;
   localparam int CLK_DIV_DEF = 4;
   localparam int DIV_W       = 8;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      DONE
   } state_t;

   // Bits needed to hold the values 0..n inclusive.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/modport_spi_clkgen.sv
// SCLK generator: divides clk by CLK_DIV and reports each half-period end,
// plus one-cycle strobes for the SCLK rising and falling edges.
module modport_spi_clkgen
   import modport_spi_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic toggle_en,
   output logic tick,
   output logic rise_tick,
   output logic fall_tick,
   output logic sclk
);

   logic [DIV_W-1:0] div_cnt;

   assign tick      = en && (div_cnt == DIV_W'(CLK_DIV - 1));
   assign rise_tick = tick && toggle_en && !sclk;
   assign fall_tick = tick && toggle_en && sclk;

   // NOTE: sequential state is written with <= so every register updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || !en) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
      end else begin
         if (tick) div_cnt <= '0;
         else      div_cnt <= div_cnt + 1'b1;

         if (rise_tick)      sclk <= 1'b1;
         else if (fall_tick) sclk <= 1'b0;
      end
   end

endmodule

// File: rtl/modport_spi.sv
// SPI master (mode 0, MSB first) moving words from a TX FIFO to the wire and
// received words into an RX FIFO. Define SPI_LOOPBACK_EN to sample MOSI instead of MISO.
module modport_spi
   import modport_spi_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pndgn,
   input  logic [WIDTH-1:0] D_pop,
   output logic             pop,
   output logic [WIDTH-1:0] D_push,
   output logic             push,
   input  logic             MISO,
   output logic             MOSI,
   output logic             SCLK,
   output logic             SCS
);

   localparam int CNT_W = cnt_width(WIDTH);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] tx_sr;
   logic [WIDTH-1:0] rx_sr;
   logic [CNT_W-1:0] bit_cnt;
   logic             clk_en;
   logic             toggle_en;
   logic             tick;
   logic             rise_tick;
   logic             fall_tick;
   logic             last_fall;
   logic             miso_int;

   assign clk_en    = (state == SETUP) || (state == SHIFT);
   assign toggle_en = (state == SHIFT);
   assign last_fall = fall_tick && (bit_cnt == CNT_W'(WIDTH));

`ifdef SPI_LOOPBACK_EN
   assign miso_int = MOSI;
`else
   assign miso_int = MISO;
`endif

   assign MOSI = clk_en ? tx_sr[WIDTH-1] : 1'b0;
   assign SCS  = !clk_en;

   modport_spi_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .clk       (clk),
      .reset     (reset),
      .en        (clk_en),
      .toggle_en (toggle_en),
      .tick      (tick),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick),
      .sclk      (SCLK)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      push       = 1'b0;
      case (state)
         IDLE: begin
            // pop is combinational so the FIFO head is consumed on the same edge it is latched.
            if (pndgn && !reset) begin
               pop        = 1'b1;
               state_next = SETUP;
            end
         end
         SETUP: begin
            if (tick) state_next = SHIFT;
         end
         SHIFT: begin
            if (last_fall) state_next = DONE;
         end
         DONE: begin
            push       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // rise/fall strobes only fire in SHIFT, so they never collide with a load in IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_sr   <= '0;
         rx_sr   <= '0;
         bit_cnt <= '0;
         D_push  <= '0;
      end else begin
         if (pop) begin
            tx_sr   <= D_pop;
            rx_sr   <= '0;
            bit_cnt <= '0;
         end
         if (rise_tick) begin
            rx_sr   <= {rx_sr[WIDTH-2:0], miso_int};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (fall_tick) tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
         if (last_fall) D_push <= rx_sr;
      end
   end

endmodule

// File: tb/tb_modport_spi.sv
// Self-checking bench for modport_spi: table of frames, back-to-back and mid-frame reset.
// Build with SPI_LOOPBACK_EN defined to check the loopback variant.
module tb_modport_spi;
   import modport_spi_pkg::*;

   localparam int W     = WIDTH_DEF;
   localparam int DIV   = CLK_DIV_DEF;
   localparam int FRAME = DIV * (2 * W + 1);
`ifdef SPI_LOOPBACK_EN
   localparam bit LOOPBACK = 1'b1;
`else
   localparam bit LOOPBACK = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         pndgn;
   logic [W-1:0] D_pop;
   logic         pop;
   logic [W-1:0] D_push;
   logic         push;
   logic         MISO = 1'b0;
   logic         MOSI;
   logic         SCLK;
   logic         SCS;

   always #5 clk = ~clk;

   modport_spi #(
      .WIDTH   (W),
      .CLK_DIV (DIV)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .pndgn  (pndgn),
      .D_pop  (D_pop),
      .pop    (pop),
      .D_push (D_push),
      .push   (push),
      .MISO   (MISO),
      .MOSI   (MOSI),
      .SCLK   (SCLK),
      .SCS    (SCS)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check_i(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [W-1:0] s);
      return LOOPBACK ? d : s;
   endfunction

   // Monitor + slave model, sampled on the falling clk edge.
   int           cyc = 0, pop_cnt = 0, push_cnt = 0, frames_started = 0;
   int           mon_rise = 0, low_cnt = 0, high_cnt = 0;
   int           frame_len = 0, frame_rises = 0, gap_len = 0;
   logic         prev_scs = 1'b1, prev_sclk = 1'b0;
   logic [W-1:0] cur_tx = '0, cur_slv = '0;
   logic [W-1:0] slv_q[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];
   int           pop_cyc_q[$];

   always @(negedge clk) begin
      cyc++;
      if (pop) begin
         pop_cnt++;
         pop_cyc_q.push_back(cyc);
         cur_tx = D_pop;
      end
      if (push) begin
         push_cnt++;
         got_q.push_back(D_push);
      end
      if (prev_scs && !SCS) begin
         frames_started++;
         gap_len  = high_cnt;
         mon_rise = 0;
         low_cnt  = 0;
         cur_slv  = (slv_q.size() > 0) ? slv_q.pop_front() : '0;
      end
      if (!prev_scs && SCS) begin
         frame_len   = low_cnt;
         frame_rises = mon_rise;
         high_cnt    = 0;
      end
      if (SCS) high_cnt++;
      else     low_cnt++;
      if (!prev_sclk && SCLK) begin
         if (mon_rise < W) check_i("mosi_bit", int'(MOSI), int'(cur_tx[W-1-mon_rise]));
         mon_rise++;
      end
      MISO      = (!SCS && mon_rise < W) ? cur_slv[W-1-mon_rise] : 1'b0;
      prev_scs  = SCS;
      prev_sclk = SCLK;
   end

   typedef struct {
      string        tag;
      logic [W-1:0] d_pop;
      logic [W-1:0] slv;
      logic [W-1:0] exp_push;
   } vec_t;

   vec_t vecs[4];

   task automatic wait_push(input int target);
      int ok;
      ok = 0;
      for (int i = 0; i < 2 * FRAME + 50; i++) begin
         @(posedge clk);
         if (push_cnt >= target) begin
            ok = 1;
            break;
         end
      end
      if (ok == 0) check_i("push_timeout", push_cnt, target);
   endtask

   task automatic compare_push(input string tag);
      logic [W-1:0] got, exp;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
         check_i({tag, "_push_present"}, got_q.size(), 1);
      end else begin
         got = got_q.pop_front();
         exp = exp_q.pop_front();
         check_w({tag, "_d_push"}, got, exp);
      end
   endtask

   task automatic run_frame(input vec_t v);
      int pops0, push0;
      pops0 = pop_cnt;
      push0 = push_cnt;
      @(posedge clk); #1;
      D_pop = v.d_pop;
      slv_q.push_back(v.slv);
      exp_q.push_back(v.exp_push);
      pndgn = 1'b1;
      @(posedge clk); #1;
      pndgn = 1'b0;
      wait_push(push0 + 1);
      check_i({v.tag, "_pops"}, pop_cnt - pops0, 1);
      check_i({v.tag, "_scs_low"}, frame_len, FRAME);
      check_i({v.tag, "_rises"}, frame_rises, W);
      compare_push(v.tag);
   endtask

   initial begin
      #(10 * 60000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pops0, push0, np, fs0, ok;
      reset = 1'b1;
      pndgn = 1'b0;
      D_pop = '0;

      vecs[0] = '{"basic",  65'h1_A5A5_A5A5_0F0F_F0F0, 65'h0_1234_5678_9ABC_DEF0, '0};
      vecs[1] = '{"zeros",  65'h0_0000_0000_0000_0000, 65'h1_FFFF_FFFF_FFFF_FFFF, '0};
      vecs[2] = '{"ends",   65'h1_0000_0000_0000_0001, 65'h0_0000_0000_0000_0000, '0};
      vecs[3] = '{"mixed",  65'h0_DEAD_BEEF_CAFE_F00D, 65'h1_5555_AAAA_3333_CCCC, '0};
      for (int i = 0; i < 4; i++) vecs[i].exp_push = model(vecs[i].d_pop, vecs[i].slv);

      // Reset held with nothing pending: bus idle every cycle.
      repeat (20) begin
         @(negedge clk);
         check_i("reset_idle", int'({SCS, SCLK, pop, push, MOSI}), 16);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check_i("idle_no_pndgn", int'({SCS, SCLK, pop, push, MOSI}), 16);
      end
      check_w("d_push_reset", D_push, '0);

      for (int i = 0; i < 4; i++) run_frame(vecs[i]);

      repeat (12) @(posedge clk);
      check_w("d_push_hold", D_push, vecs[3].exp_push);

      // Two words queued back to back with pndgn held high.
      pops0 = pop_cnt;
      push0 = push_cnt;
      np    = pop_cyc_q.size();
      @(posedge clk); #1;
      D_pop = vecs[3].d_pop;
      slv_q.push_back(vecs[0].slv);
      slv_q.push_back(vecs[3].slv);
      exp_q.push_back(model(vecs[3].d_pop, vecs[0].slv));
      exp_q.push_back(model(vecs[0].d_pop, vecs[3].slv));
      pndgn = 1'b1;
      @(posedge clk); #1;
      D_pop = vecs[0].d_pop;
      ok = 0;
      for (int i = 0; i < 2 * FRAME + 20; i++) begin
         @(posedge clk);
         if (pop_cnt >= pops0 + 2) begin
            ok = 1;
            break;
         end
      end
      #1 pndgn = 1'b0;
      check_i("b2b_two_pops", ok, 1);
      wait_push(push0 + 2);
      if (pop_cyc_q.size() >= np + 2)
         check_i("b2b_pop_spacing", pop_cyc_q[np+1] - pop_cyc_q[np], FRAME + 2);
      else
         check_i("b2b_pop_count", pop_cyc_q.size() - np, 2);
      // Between frames SCS is high for the DONE cycle and the following pop cycle.
      check_i("b2b_scs_gap", gap_len, 2);
      check_i("b2b_scs_low", frame_len, FRAME);
      compare_push("b2b_first");
      compare_push("b2b_second");

      // Reset around the 30th SCLK rising edge: frame dropped, no push.
      push0 = push_cnt;
      fs0   = frames_started;
      @(posedge clk); #1;
      D_pop = vecs[3].d_pop;
      slv_q.push_back(vecs[3].slv);
      pndgn = 1'b1;
      @(posedge clk); #1;
      pndgn = 1'b0;
      ok = 0;
      for (int i = 0; i < FRAME; i++) begin
         @(posedge clk);
         if (frames_started > fs0 && mon_rise >= 30) begin
            ok = 1;
            break;
         end
      end
      check_i("abort_reached_edge30", ok, 1);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      check_i("abort_bus_idle", int'({SCS, SCLK, push, MOSI}), 8);
      reset = 1'b0;
      slv_q.delete();
      repeat (40) @(posedge clk);
      check_i("abort_no_push", push_cnt - push0, 0);
      check_i("abort_rises_cut", int'(frame_rises < W), 1);

      run_frame(vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
